// File: rtl/usart_bus_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the USART register port.
// The arbiter takes the master modport because it masters the USART register bus.
interface usart_bus_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_ack;
  logic              m0_err;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_ack;
  logic              m1_err;
  logic [DATA_W-1:0] m1_rdata;

  logic              s_sel;
  logic              s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic [DATA_W-1:0] s_rdata;
  logic              s_ready;

  modport master (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  s_rdata, s_ready,
    output m0_gnt, m0_ack, m0_err, m0_rdata,
    output m1_gnt, m1_ack, m1_err, m1_rdata,
    output s_sel, s_we, s_addr, s_wdata
  );

  modport slave (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output s_rdata, s_ready,
    input  m0_gnt, m0_ack, m0_err, m0_rdata,
    input  m1_gnt, m1_ack, m1_err, m1_rdata,
    input  s_sel, s_we, s_addr, s_wdata
  );
endinterface

// File: rtl/usart_bus_arbiter.sv
// Round-robin two-master arbiter/sequencer for the USART register port; gnt+s_sel on the sampling edge,
// ack on the edge s_ready (or timeout) is seen. Requests wait while an access is in flight.
module usart_bus_arbiter #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input logic               clk,
    input logic               rst,
    usart_bus_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t            state;
  logic [7:0]        cnt;
  logic              last_grant;
  logic              owner;
  logic              win;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [DATA_W-1:0] rsp_data;

  always_comb begin
    win       = (bus.m0_req && bus.m1_req) ? ~last_grant : bus.m1_req;
    win_we    = win ? bus.m1_we    : bus.m0_we;
    win_addr  = win ? bus.m1_addr  : bus.m0_addr;
    win_wdata = win ? bus.m1_wdata : bus.m0_wdata;
    // Writes return zero data regardless of what the USART drives.
    rsp_data  = bus.s_we ? '0 : bus.s_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      last_grant   <= 1'b1;
      owner        <= 1'b0;
      bus.m0_gnt   <= 1'b0;
      bus.m0_ack   <= 1'b0;
      bus.m0_err   <= 1'b0;
      bus.m0_rdata <= '0;
      bus.m1_gnt   <= 1'b0;
      bus.m1_ack   <= 1'b0;
      bus.m1_err   <= 1'b0;
      bus.m1_rdata <= '0;
      bus.s_sel    <= 1'b0;
      bus.s_we     <= 1'b0;
      bus.s_addr   <= '0;
      bus.s_wdata  <= '0;
    end else begin
      bus.m0_gnt <= 1'b0;
      bus.m1_gnt <= 1'b0;
      bus.m0_ack <= 1'b0;
      bus.m1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.m0_req || bus.m1_req) begin
            state       <= ACCESS;
            owner       <= win;
            bus.m0_gnt  <= ~win;
            bus.m1_gnt  <= win;
            bus.s_sel   <= 1'b1;
            bus.s_we    <= win_we;
            bus.s_addr  <= win_addr;
            bus.s_wdata <= win_wdata;
            cnt         <= '0;
          end
        end
        ACCESS: begin
          // s_ready is checked first so a response on the timeout cycle still succeeds.
          if (bus.s_ready) begin
            state     <= RESP;
            bus.s_sel <= 1'b0;
            if (owner) begin
              bus.m1_ack   <= 1'b1;
              bus.m1_err   <= 1'b0;
              bus.m1_rdata <= rsp_data;
            end else begin
              bus.m0_ack   <= 1'b1;
              bus.m0_err   <= 1'b0;
              bus.m0_rdata <= rsp_data;
            end
          end else if (cnt == TMO) begin
            state     <= RESP;
            bus.s_sel <= 1'b0;
            if (owner) begin
              bus.m1_ack   <= 1'b1;
              bus.m1_err   <= 1'b1;
              bus.m1_rdata <= '0;
            end else begin
              bus.m0_ack   <= 1'b1;
              bus.m0_err   <= 1'b1;
              bus.m0_rdata <= '0;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          last_grant <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_usart_bus_arbiter.sv
// Directed plus randomized bench for usart_bus_arbiter against a transaction-level model
// (round-robin winner, response-cycle count, per-master held response fields).
module tb_usart_bus_arbiter;
  localparam int TMO = 15;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  usart_bus_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  usart_bus_arbiter #(.ADDR_W(4), .DATA_W(8), .TIMEOUT(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state
  bit         exp_last;
  logic       f_we    [2];
  logic [3:0] f_addr  [2];
  logic [7:0] f_wdata [2];
  logic [7:0] exp_rdata [2];
  logic       exp_err   [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_last     = 1'b1;
    exp_rdata[0] = 8'h00;
    exp_rdata[1] = 8'h00;
    exp_err[0]   = 1'b0;
    exp_err[1]   = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_s"}, {bus.s_sel, bus.s_we, bus.s_addr, bus.s_wdata}, 32'h0);
    chk({tag, "_m"}, {bus.m0_gnt, bus.m1_gnt, bus.m0_ack, bus.m1_ack, bus.m0_err,
                      bus.m1_err, bus.m0_rdata, bus.m1_rdata}, 32'h0);
  endtask

  task automatic set_req(input bit m, input logic we, input logic [3:0] addr,
                         input logic [7:0] wdata);
    f_we[m]    = we;
    f_addr[m]  = addr;
    f_wdata[m] = wdata;
    if (m) begin
      bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
    end else begin
      bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
    end
  endtask

  // rdy_at: ACCESS cycle (1-based) in which s_ready is driven high; 0 = never.
  task automatic do_access(input bit rel, input int rdy_at, input logic [7:0] rd);
    bit   w;
    bit   got;
    int   n;
    int   gcnt;
    int   exp_sel;
    logic e_err;
    logic [7:0] e_data;
    w   = (bus.m0_req && bus.m1_req) ? ~exp_last : bus.m1_req;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      #1;
      got = bus.m0_gnt | bus.m1_gnt;
    end
    chk("gnt_seen", got, 1);
    chk("gnt_m0", bus.m0_gnt, !w);
    chk("gnt_m1", bus.m1_gnt, w);
    chk("s_sel_at_gnt", bus.s_sel, 1);
    chk("s_we", bus.s_we, f_we[w]);
    chk("s_addr", bus.s_addr, f_addr[w]);
    chk("s_wdata", bus.s_wdata, f_wdata[w]);
    if (rel) begin
      if (w) bus.m1_req = 1'b0;
      else   bus.m0_req = 1'b0;
    end
    n    = 1;
    gcnt = 0;
    while (bus.s_sel && n <= 40) begin
      gcnt += int'(bus.m0_gnt) + int'(bus.m1_gnt);
      bus.s_ready = (n == rdy_at);
      bus.s_rdata = (n == rdy_at) ? rd : 8'($urandom);
      @(posedge clk);
      #1;
      n++;
    end
    bus.s_ready = 1'b0;
    if (rdy_at >= 1 && rdy_at <= TMO + 1) begin
      exp_sel = rdy_at;
      e_err   = 1'b0;
      e_data  = f_we[w] ? 8'h00 : rd;
    end else begin
      exp_sel = TMO + 1;
      e_err   = 1'b1;
      e_data  = 8'h00;
    end
    exp_rdata[w] = e_data;
    exp_err[w]   = e_err;
    exp_last     = w;
    chk("gnt_pulses", gcnt, 1);
    chk("sel_cycles", n - 1, exp_sel);
    chk("ack_m0", bus.m0_ack, !w);
    chk("ack_m1", bus.m1_ack, w);
    chk("err_m0", bus.m0_err, exp_err[0]);
    chk("err_m1", bus.m1_err, exp_err[1]);
    chk("rdata_m0", bus.m0_rdata, exp_rdata[0]);
    chk("rdata_m1", bus.m1_rdata, exp_rdata[1]);
    @(posedge clk);
    #1;
    chk("post_ack", {bus.m0_ack, bus.m1_ack, bus.m0_gnt, bus.m1_gnt, bus.s_sel}, 0);
  endtask

  initial begin
    bit got;
    int acks;
    int r;
    int rdy;
    tests = 0;
    fails = 0;
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
    bus.s_ready = 0; bus.s_rdata = 0;
    pulse_reset();
    check_all_zero("reset");

    // Single read from m0, ready on 2nd ACCESS cycle
    set_req(1'b0, 1'b0, 4'h3, 8'h00);
    do_access(1'b1, 2, 8'hA5);

    // Contention from reset, both held
    pulse_reset();
    set_req(1'b0, 1'b0, 4'hA, 8'h00);
    set_req(1'b1, 1'b1, 4'h6, 8'h11);
    do_access(1'b0, 1, 8'h21);
    do_access(1'b0, 3, 8'h22);
    do_access(1'b1, 2, 8'h23);
    do_access(1'b1, 1, 8'h24);

    // Write from m1
    set_req(1'b1, 1'b1, 4'h1, 8'h5C);
    do_access(1'b1, 2, 8'hFF);

    // Timeout, then ready on the timeout cycle
    set_req(1'b0, 1'b0, 4'h7, 8'h00);
    do_access(1'b1, 0, 8'h33);
    set_req(1'b0, 1'b0, 4'h2, 8'h00);
    do_access(1'b1, TMO + 1, 8'h6E);

    // Reset on the 3rd ACCESS cycle
    set_req(1'b0, 1'b0, 4'h5, 8'h00);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      #1;
      got = bus.m0_gnt;
    end
    chk("rst_gnt_seen", got, 1);
    bus.m0_req = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("mid_rst");
    rst = 1'b0;
    model_reset();
    acks = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      acks += int'(bus.m0_ack) + int'(bus.m1_ack);
    end
    chk("no_ack_after_rst", acks, 0);
    set_req(1'b0, 1'b0, 4'h9, 8'h00);
    set_req(1'b1, 1'b0, 4'hC, 8'h00);
    do_access(1'b1, 1, 8'h5A);
    do_access(1'b1, 1, 8'hC3);

    // Randomized traffic with leftover pending requests
    for (int it = 0; it < 24; it++) begin
      if (!bus.m0_req && $urandom_range(0, 1) == 1)
        set_req(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
      if (!bus.m1_req && $urandom_range(0, 1) == 1)
        set_req(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
      if (!bus.m0_req && !bus.m1_req)
        set_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), 8'($urandom));
      r   = int'($urandom_range(0, 9));
      rdy = (r == 0) ? 0 : (r == 1) ? TMO + 1 : int'($urandom_range(1, 5));
      do_access(1'b1, rdy, 8'($urandom));
    end
    repeat (2) begin
      if (bus.m0_req || bus.m1_req) do_access(1'b1, 1, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
